uart_tx: RTL and testbench

UART transmitter that serialises one byte per request into an 8N1 frame (one start bit, eight data bits LSB first, one stop bit, no parity) on a single line that idles high. It pairs with `uart_rx` on the same link: same bit period, same frame format, same idle level. It sits between a byte-producing client (host logic, test stimulus) and the board TX pin, and uses a simple start/busy/done handshake.

---
 rtl/uart_pkg.sv | 14 +
 rtl/uart_bit_timer.sv | 34 +++
 rtl/uart_tx.sv | 96 +++++++++
 tb/tb_uart_tx.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART constants: one-hot FSM encodings, bit-period presets and frame width.
// Used by uart_tx, uart_rx and uart_bit_timer so both ends of the link agree on timing.
package uart_pkg;

    localparam int CLKS_PER_BIT_SIM      = 10;
    localparam int CLKS_PER_BIT_50M_9600 = 5208;
    localparam int DATA_BITS             = 8;

    localparam logic [3:0] ST_IDLE  = 4'b0001;
    localparam logic [3:0] ST_START = 4'b0010;
    localparam logic [3:0] ST_DATA  = 4'b0100;
    localparam logic [3:0] ST_STOP  = 4'b1000;

endpackage

// File: rtl/uart_bit_timer.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 while en is high, held at 0 otherwise.
// tick marks the last cycle of a bit; half_tick marks the mid-bit sample point (for uart_rx).
module uart_bit_timer
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_SIM
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    output logic tick,
    output logic half_tick
);

    localparam int TW = $clog2(CLKS_PER_BIT);
    localparam logic [TW-1:0] LAST = TW'(CLKS_PER_BIT - 1);
    localparam logic [TW-1:0] HALF = TW'(CLKS_PER_BIT / 2 - 1);

    logic [TW-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (!en || cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign tick      = en && (cnt == LAST);
    assign half_tick = en && (cnt == HALF);

endmodule

// File: rtl/uart_tx.sv
// 8N1 UART transmitter: start accepted in IDLE, tx_o falls next cycle, frame lasts 10*CLKS_PER_BIT.
// No queuing: tx_start_i is ignored while busy; done pulses in the first IDLE cycle.
module uart_tx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_SIM
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 tx_start_i,
    input  logic [DATA_BITS-1:0] data_i,
    output logic                 tx_o,
    output logic                 tx_busy_o,
    output logic                 tx_done_o
);

    localparam logic [2:0] LAST_IDX = 3'(DATA_BITS - 1);

    logic [3:0]           state, state_nxt;
    logic [DATA_BITS-1:0] shift, shift_nxt;
    logic [2:0]           bit_idx, bit_idx_nxt;
    logic                 tick, half_tick;

    uart_bit_timer #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_bit_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (state != ST_IDLE),
        .tick     (tick),
        .half_tick(half_tick)
    );

    always_comb begin
        state_nxt   = state;
        shift_nxt   = shift;
        bit_idx_nxt = bit_idx;
        case (state)
            ST_IDLE: begin
                if (tx_start_i) begin
                    state_nxt = ST_START;
                    shift_nxt = data_i;
                end
            end
            ST_START: begin
                if (tick) begin
                    state_nxt   = ST_DATA;
                    bit_idx_nxt = '0;
                end
            end
            ST_DATA: begin
                if (tick) begin
                    shift_nxt = shift >> 1;
                    if (bit_idx == LAST_IDX) begin
                        state_nxt = ST_STOP;
                    end else begin
                        bit_idx_nxt = bit_idx + 1'b1;
                    end
                end
            end
            ST_STOP: begin
                if (tick) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Outputs are registered from next-state values so tx_o changes in the cycle after acceptance.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            shift     <= '0;
            bit_idx   <= '0;
            tx_o      <= 1'b1;
            tx_busy_o <= 1'b0;
            tx_done_o <= 1'b0;
        end else begin
            state     <= state_nxt;
            shift     <= shift_nxt;
            bit_idx   <= bit_idx_nxt;
            tx_busy_o <= (state_nxt != ST_IDLE);
            tx_done_o <= (state == ST_STOP) && tick;
            case (state_nxt)
                ST_START: tx_o <= 1'b0;
                ST_DATA:  tx_o <= shift_nxt[0];
                default:  tx_o <= 1'b1;
            endcase
        end
    end

    // The mid-bit strobe is only consumed by the receiver; here it must never coincide with end-of-bit.
    a_tick_distinct: assert property (@(posedge clk) disable iff (!rst_n) !(tick && half_tick));

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: line decoder feeds a scoreboard of received frames, plus per-cycle timing checks.
`timescale 1ns/1ps
module tb_uart_tx;
    import uart_pkg::*;

    localparam int C  = 10;
    localparam int C2 = 2;
    localparam int CB = 5208;

    typedef struct {
        logic [7:0] b;
        logic       start_ok;
        logic       stop_ok;
        int         fall;
        int         hi_run;
    } rx_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic       tx_start_i = 1'b0;
    logic [7:0] data_i = 8'h00;
    logic       tx_o, tx_busy_o, tx_done_o;
    logic       start2 = 1'b0, startb = 1'b0;
    logic [7:0] data2 = 8'h00, datab = 8'h00;
    logic       tx2, busy2, done2, txb, busyb, doneb;

    uart_tx #(.CLKS_PER_BIT(C)) dut (
        .clk(clk), .rst_n(rst_n), .tx_start_i(tx_start_i), .data_i(data_i),
        .tx_o(tx_o), .tx_busy_o(tx_busy_o), .tx_done_o(tx_done_o)
    );
    uart_tx #(.CLKS_PER_BIT(C2)) dut2 (
        .clk(clk), .rst_n(rst_n), .tx_start_i(start2), .data_i(data2),
        .tx_o(tx2), .tx_busy_o(busy2), .tx_done_o(done2)
    );
    uart_tx #(.CLKS_PER_BIT(CB)) dutb (
        .clk(clk), .rst_n(rst_n), .tx_start_i(startb), .data_i(datab),
        .tx_o(txb), .tx_busy_o(busyb), .tx_done_o(doneb)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;
    logic [7:0] exp_q[$];
    rx_t        rx_q[$];
    int         done_cnt = 0;

    // Line decoder for the main DUT: samples mid-bit, abandons a frame on reset.
    int  m_st = 0, m_fall = 0, m_off = 0, m_hi = 0;
    rx_t m_cur;
    initial begin
        forever begin
            @(posedge clk);
            #2;
            if (!rst_n) begin
                m_st = 0;
                m_hi = 0;
            end else begin
                if (tx_done_o === 1'b1) done_cnt++;
                if (m_st == 0) begin
                    if (tx_o === 1'b0) begin
                        m_st = 1;
                        m_fall = cyc;
                        m_cur.hi_run = m_hi;
                        m_cur.b = 8'h00;
                    end
                end else begin
                    m_off = cyc - m_fall;
                    if (m_off == C / 2) begin
                        m_cur.start_ok = (tx_o === 1'b0);
                    end else if (m_off == C / 2 + 9 * C) begin
                        m_cur.stop_ok = (tx_o === 1'b1);
                        m_cur.fall = m_fall;
                        rx_q.push_back(m_cur);
                        m_st = 0;
                    end else if (m_off > C / 2 && (m_off - C / 2) % C == 0) begin
                        m_cur.b[(m_off - C / 2) / C - 1] = tx_o;
                    end
                end
                m_hi = (tx_o === 1'b1) ? m_hi + 1 : 0;
            end
        end
    end

    task automatic pulse(input logic [7:0] b, output int n);
        @(negedge clk);
        tx_start_i = 1'b1;
        data_i = b;
        n = cyc;
        exp_q.push_back(b);
        @(negedge clk);
        tx_start_i = 1'b0;
        data_i = 8'($urandom);
    endtask

    task automatic wait_done(input int budget, output int dcyc);
        dcyc = -1;
        for (int i = 0; i < budget; i++) begin
            if (tx_done_o === 1'b1) begin
                dcyc = cyc;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        #12;
        n_cmp++; if (tx_o !== 1'b1)      begin n_bad++; $display("FAIL reset_tx got %b want 1", tx_o); end
        n_cmp++; if (tx_busy_o !== 1'b0) begin n_bad++; $display("FAIL reset_busy got %b want 0", tx_busy_o); end
        n_cmp++; if (tx_done_o !== 1'b0) begin n_bad++; $display("FAIL reset_done got %b want 0", tx_done_o); end
        n_cmp++; if ({tx2, txb} !== 2'b11) begin n_bad++; $display("FAIL reset_tx_sweep got %b want 11", {tx2, txb}); end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        n_cmp++; if ({tx_o, tx_busy_o, tx_done_o} !== 3'b100) begin
            n_bad++; $display("FAIL idle_after_reset got %b want 100", {tx_o, tx_busy_o, tx_done_o});
        end
    endtask

    task automatic test_single_a5();
        int n;
        rx_t r;
        logic [7:0] e;
        logic [9:0] fr;
        logic exp_tx;
        fr = {1'b1, 8'hA5, 1'b0};
        pulse(8'hA5, n);
        for (int k = 1; k <= 10 * C + 1; k++) begin
            if (k > 1) @(negedge clk);
            exp_tx = (k <= 10 * C) ? fr[(k - 1) / C] : 1'b1;
            n_cmp++; if (tx_o !== exp_tx) begin n_bad++; $display("FAIL a5_tx cyc N+%0d got %b want %b", k, tx_o, exp_tx); end
            n_cmp++; if (tx_busy_o !== (k <= 10 * C)) begin n_bad++; $display("FAIL a5_busy cyc N+%0d got %b", k, tx_busy_o); end
            n_cmp++; if (tx_done_o !== (k == 10 * C + 1)) begin n_bad++; $display("FAIL a5_done cyc N+%0d got %b", k, tx_done_o); end
        end
        @(negedge clk);
        if (rx_q.size() == 0) begin
            n_cmp++; n_bad++; $display("FAIL a5_rx got no frame want A5");
        end else begin
            r = rx_q.pop_front();
            e = exp_q.pop_front();
            n_cmp++; if (r.b !== e) begin n_bad++; $display("FAIL a5_rx_byte got %h want %h", r.b, e); end
            n_cmp++; if ({r.start_ok, r.stop_ok} !== 2'b11) begin n_bad++; $display("FAIL a5_rx_framing got %b want 11", {r.start_ok, r.stop_ok}); end
        end
    endtask

    task automatic test_loopback();
        logic [7:0] bytes[3];
        int n, d;
        rx_t r;
        logic [7:0] e;
        bytes[0] = 8'h00; bytes[1] = 8'hFF; bytes[2] = 8'h3C;
        for (int i = 0; i < 3; i++) begin
            pulse(bytes[i], n);
            wait_done(12 * C, d);
            n_cmp++; if (d != n + 10 * C + 1) begin n_bad++; $display("FAIL loop_done_cyc byte %h got %0d want %0d", bytes[i], d, n + 10 * C + 1); end
            n_cmp++; if (tx_busy_o !== 1'b0) begin n_bad++; $display("FAIL loop_busy_at_done got %b want 0", tx_busy_o); end
            if (rx_q.size() == 0) begin
                n_cmp++; n_bad++; $display("FAIL loop_rx got no frame want %h", bytes[i]);
            end else begin
                r = rx_q.pop_front();
                e = exp_q.pop_front();
                n_cmp++; if (r.b !== e) begin n_bad++; $display("FAIL loop_rx_byte got %h want %h", r.b, e); end
                n_cmp++; if (r.fall != n + 1) begin n_bad++; $display("FAIL loop_fall_cyc got %0d want %0d", r.fall, n + 1); end
                n_cmp++; if ({r.start_ok, r.stop_ok} !== 2'b11) begin n_bad++; $display("FAIL loop_framing got %b want 11", {r.start_ok, r.stop_ok}); end
            end
            repeat (3) @(negedge clk);
        end
    endtask

    task automatic test_back_to_back();
        int n, n2, d, d2;
        int want_fall[2];
        rx_t r;
        logic [7:0] e;
        pulse(8'h7E, n);
        wait_done(12 * C, d);
        tx_start_i = 1'b1;
        data_i = 8'h81;
        n2 = cyc;
        exp_q.push_back(8'h81);
        @(negedge clk);
        tx_start_i = 1'b0;
        n_cmp++; if (d != n + 10 * C + 1) begin n_bad++; $display("FAIL b2b_done1 got %0d want %0d", d, n + 10 * C + 1); end
        wait_done(12 * C, d2);
        n_cmp++; if (d2 != n2 + 10 * C + 1) begin n_bad++; $display("FAIL b2b_done2 got %0d want %0d", d2, n2 + 10 * C + 1); end
        @(negedge clk);
        want_fall[0] = n + 1;
        want_fall[1] = n2 + 1;
        n_cmp++; if (rx_q.size() != 2) begin n_bad++; $display("FAIL b2b_frames got %0d want 2", rx_q.size()); end
        for (int i = 0; i < 2; i++) begin
            if (rx_q.size() > 0) begin
                r = rx_q.pop_front();
                e = exp_q.pop_front();
                n_cmp++; if (r.b !== e) begin n_bad++; $display("FAIL b2b_byte%0d got %h want %h", i, r.b, e); end
                n_cmp++; if (r.fall != want_fall[i]) begin n_bad++; $display("FAIL b2b_fall%0d got %0d want %0d", i, r.fall, want_fall[i]); end
                if (i == 1) begin
                    n_cmp++; if (r.hi_run != C + 1) begin n_bad++; $display("FAIL b2b_gap got %0d want %0d", r.hi_run, C + 1); end
                end
            end
        end
        exp_q.delete();
    endtask

    task automatic test_start_while_busy();
        int n, d, d0;
        rx_t r;
        logic [7:0] e;
        d0 = done_cnt;
        pulse(8'h0F, n);
        repeat (3 * C) @(negedge clk);
        tx_start_i = 1'b1;
        data_i = 8'h55;
        @(negedge clk);
        tx_start_i = 1'b0;
        wait_done(12 * C, d);
        n_cmp++; if (d != n + 10 * C + 1) begin n_bad++; $display("FAIL busy_done_cyc got %0d want %0d", d, n + 10 * C + 1); end
        repeat (12 * C) @(negedge clk);
        n_cmp++; if (done_cnt != d0 + 1) begin n_bad++; $display("FAIL busy_done_pulses got %0d want %0d", done_cnt - d0, 1); end
        n_cmp++; if (rx_q.size() != 1) begin n_bad++; $display("FAIL busy_frames got %0d want 1", rx_q.size()); end
        if (rx_q.size() > 0) begin
            r = rx_q.pop_front();
            e = exp_q.pop_front();
            n_cmp++; if (r.b !== e) begin n_bad++; $display("FAIL busy_byte got %h want %h", r.b, e); end
            n_cmp++; if (r.fall != n + 1) begin n_bad++; $display("FAIL busy_fall got %0d want %0d", r.fall, n + 1); end
        end
        rx_q.delete();
        exp_q.delete();
    endtask

    task automatic test_reset_mid();
        int n, d, d0;
        rx_t r;
        logic [7:0] e;
        pulse(8'hF0, n);
        void'(exp_q.pop_back());
        repeat (4 * C + C / 2 - 1) @(negedge clk);
        n_cmp++; if (tx_o !== 1'b0) begin n_bad++; $display("FAIL rst_mid_bit3 got %b want 0", tx_o); end
        d0 = done_cnt;
        rst_n = 1'b0;
        #1;
        n_cmp++; if (tx_o !== 1'b1)      begin n_bad++; $display("FAIL rst_mid_tx got %b want 1", tx_o); end
        n_cmp++; if (tx_busy_o !== 1'b0) begin n_bad++; $display("FAIL rst_mid_busy got %b want 0", tx_busy_o); end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (12 * C) @(negedge clk);
        n_cmp++; if (done_cnt != d0) begin n_bad++; $display("FAIL rst_mid_done got %0d pulses want 0", done_cnt - d0); end
        n_cmp++; if (rx_q.size() != 0) begin n_bad++; $display("FAIL rst_mid_partial got %0d frames want 0", rx_q.size()); end
        rx_q.delete();
        pulse(8'hC3, n);
        wait_done(12 * C, d);
        @(negedge clk);
        n_cmp++; if (d != n + 10 * C + 1) begin n_bad++; $display("FAIL rst_c3_done got %0d want %0d", d, n + 10 * C + 1); end
        if (rx_q.size() == 0) begin
            n_cmp++; n_bad++; $display("FAIL rst_c3_rx got no frame want C3");
        end else begin
            r = rx_q.pop_front();
            e = exp_q.pop_front();
            n_cmp++; if (r.b !== e) begin n_bad++; $display("FAIL rst_c3_byte got %h want %h", r.b, e); end
            n_cmp++; if (r.fall != n + 1) begin n_bad++; $display("FAIL rst_c3_fall got %0d want %0d", r.fall, n + 1); end
        end
    endtask

    // 0x55 toggles the line at every bit boundary, so edge spacing is the bit period.
    task automatic test_param_sweep(input int sel, input int cp);
        int n, dcyc;
        int edges[$];
        logic prev, cur, dn, bz;
        @(negedge clk);
        if (sel == 0) begin start2 = 1'b1; data2 = 8'h55; end
        else          begin startb = 1'b1; datab = 8'h55; end
        n = cyc;
        @(negedge clk);
        start2 = 1'b0;
        startb = 1'b0;
        prev = 1'b1;
        dcyc = -1;
        bz = 1'b1;
        for (int k = 0; k < 10 * cp + 4; k++) begin
            cur = (sel == 0) ? tx2 : txb;
            dn  = (sel == 0) ? done2 : doneb;
            if (cur !== prev) edges.push_back(cyc);
            prev = cur;
            if (dn === 1'b1) begin
                dcyc = cyc;
                bz = (sel == 0) ? busy2 : busyb;
                break;
            end
            @(negedge clk);
        end
        n_cmp++; if (edges.size() != 10) begin n_bad++; $display("FAIL sweep%0d_edges got %0d want 10", cp, edges.size()); end
        if (edges.size() > 0) begin
            n_cmp++; if (edges[0] != n + 1) begin n_bad++; $display("FAIL sweep%0d_fall got %0d want %0d", cp, edges[0], n + 1); end
        end
        for (int i = 1; i < edges.size(); i++) begin
            n_cmp++; if (edges[i] - edges[i-1] != cp) begin n_bad++; $display("FAIL sweep%0d_period%0d got %0d want %0d", cp, i, edges[i] - edges[i-1], cp); end
        end
        n_cmp++; if (dcyc != n + 10 * cp + 1) begin n_bad++; $display("FAIL sweep%0d_frame got %0d want %0d", cp, dcyc - n - 1, 10 * cp); end
        n_cmp++; if (bz !== 1'b0) begin n_bad++; $display("FAIL sweep%0d_busy_at_done got %b want 0", cp, bz); end
    endtask

    initial begin
        test_reset();
        test_single_a5();
        test_loopback();
        test_back_to_back();
        test_start_while_busy();
        test_reset_mid();
        test_param_sweep(0, C2);
        test_param_sweep(1, CB);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
